// File: rtl/cardinal_nic_pkg.sv
//------------------------------------------------------------------------------
// Module   : cardinal_nic_pkg
// Brief    : NIC register map, status bit, word width and arbiter state type.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cardinal_nic_pkg;

  localparam int WORD_W = 64;
  localparam int NIC_STATUS_BIT = 63;

  localparam logic [1:0] NIC_NET_IN         = 2'b00;
  localparam logic [1:0] NIC_NET_IN_STATUS  = 2'b01;
  localparam logic [1:0] NIC_NET_OUT        = 2'b10;
  localparam logic [1:0] NIC_NET_OUT_STATUS = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POLL = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker: first request at or after ptr.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  int w_idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    w_idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (32'(ptr) + k) % NUM_REQ;
      if (!grant_valid && req[w_idx[IDX_W-1:0]]) begin
        grant_valid               = 1'b1;
        grant[w_idx[IDX_W-1:0]]   = 1'b1;
        grant_idx                 = w_idx[IDX_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cardinal_nic_arbiter.sv
//------------------------------------------------------------------------------
// Module   : cardinal_nic_arbiter
// Brief    : Round-robin sharing of one cardinal NIC register port; polls the
//            status register, then performs a single send or receive access.
//            Optional poll timeout enabled by defining NIC_ARB_TIMEOUT_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cardinal_nic_arbiter
  import cardinal_nic_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        wr,
  input  logic [NUM_REQ*WORD_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic [0:WORD_W-1]         rdata,
  output logic                      busy,
  output logic [0:1]                nic_addr,
  output logic                      nic_en,
  output logic                      nic_en_wr,
  output logic [0:WORD_W-1]         nic_wdata,
  input  logic [0:WORD_W-1]         nic_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t              r_state;
  logic [IDX_W-1:0]    r_sel;
  logic [NUM_REQ-1:0]  r_sel_oh;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic                r_wr;
  logic [WORD_W-1:0]   r_word;
  logic [NUM_REQ-1:0]  r_done;
  logic [NUM_REQ-1:0]  r_err;
  logic [0:WORD_W-1]   r_rdata;
  logic [0:1]          r_nic_addr;
  logic                r_nic_en;
  logic                r_nic_en_wr;
  logic [0:WORD_W-1]   r_nic_wdata;

  logic [NUM_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]    w_grant_idx;
  logic                w_grant_valid;
  logic [WORD_W-1:0]   w_word_sel;
  logic                w_wr_sel;
  logic                w_status;
  logic                w_proceed;
  logic                w_req_held;
  logic                w_timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req         (req),
    .ptr         (r_rr_ptr),
    .grant       (w_grant),
    .grant_idx   (w_grant_idx),
    .grant_valid (w_grant_valid)
  );

  always_comb begin
    w_word_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_word_sel = wdata[WORD_W*i +: WORD_W];
    end
  end

  assign w_wr_sel   = |(wr & w_grant);
  assign w_status   = nic_rdata[NIC_STATUS_BIT];
  // A send waits for an empty output buffer, a receive for a full input one.
  assign w_proceed  = r_wr ? !w_status : w_status;
  assign w_req_held = |(req & r_sel_oh);

`ifdef NIC_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] r_poll_cnt;

  always_ff @(posedge clk) begin
    if (!reset || r_state != POLL) r_poll_cnt <= '0;
    else                           r_poll_cnt <= r_poll_cnt + 1'b1;
  end

  assign w_timeout = (r_state == POLL) && (r_poll_cnt == CNT_W'(TIMEOUT - 1));
`else
  // Never true for a legal TIMEOUT; POLL waits indefinitely in this build.
  assign w_timeout = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_sel_oh    <= '0;
      r_rr_ptr    <= '0;
      r_wr        <= 1'b0;
      r_word      <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_rdata     <= '0;
      r_nic_addr  <= '0;
      r_nic_en    <= 1'b0;
      r_nic_en_wr <= 1'b0;
      r_nic_wdata <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_state     <= POLL;
            r_sel       <= w_grant_idx;
            r_sel_oh    <= w_grant;
            r_wr        <= w_wr_sel;
            r_word      <= w_word_sel;
            r_nic_en    <= 1'b1;
            r_nic_en_wr <= 1'b0;
            r_nic_addr  <= w_wr_sel ? NIC_NET_OUT_STATUS : NIC_NET_IN_STATUS;
          end
        end
        POLL: begin
          if (!w_req_held) begin
            r_state    <= IDLE;
            r_nic_en   <= 1'b0;
            r_nic_addr <= '0;
          end else if (w_proceed) begin
            r_state     <= XFER;
            r_nic_en_wr <= r_wr;
            r_nic_addr  <= r_wr ? NIC_NET_OUT : NIC_NET_IN;
            r_nic_wdata <= r_wr ? r_word : '0;
          end else if (w_timeout) begin
            r_state    <= DONE;
            r_nic_en   <= 1'b0;
            r_nic_addr <= '0;
            r_done     <= r_sel_oh;
            r_err      <= r_sel_oh;
          end
        end
        XFER: begin
          r_state     <= DONE;
          r_nic_en    <= 1'b0;
          r_nic_en_wr <= 1'b0;
          r_nic_addr  <= '0;
          r_nic_wdata <= '0;
          r_done      <= r_sel_oh;
          if (!r_wr) r_rdata <= nic_rdata;
        end
        DONE: begin
          r_state  <= IDLE;
          r_rr_ptr <= (r_sel == IDX_W'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;
        end
      endcase
    end
  end

  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign busy      = (r_state != IDLE);
  assign nic_addr  = r_nic_addr;
  assign nic_en    = r_nic_en;
  assign nic_en_wr = r_nic_en_wr;
  assign nic_wdata = r_nic_wdata;

endmodule

`default_nettype wire

// File: tb/tb_cardinal_nic_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_cardinal_nic_arbiter
// Brief    : Directed bench for cardinal_nic_arbiter with a small NIC model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cardinal_nic_arbiter;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [1:0]    wr;
  logic [127:0]  wdata;
  logic [1:0]    done;
  logic [1:0]    err;
  logic [0:63]   rdata;
  logic          busy;
  logic [0:1]    nic_addr;
  logic          nic_en;
  logic          nic_en_wr;
  logic [0:63]   nic_wdata;
  logic [0:63]   nic_rdata;

  logic          out_full;
  logic          in_full;
  logic [63:0]   in_word;
  int            wr_count = 0;
  int            rd_count = 0;
  logic [63:0]   last_wr  = '0;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            snap;

  localparam logic [63:0] SEND_W  = 64'hDEADBEEF_00000001;
  localparam logic [63:0] RECV_W  = 64'h01234567_89ABCDEF;
  localparam logic [63:0] WORD0   = 64'hA0A0A0A0_00000000;
  localparam logic [63:0] WORD1   = 64'hB1B1B1B1_11111111;

  cardinal_nic_arbiter #(
    .NUM_REQ (2),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .wr        (wr),
    .wdata     (wdata),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .nic_addr  (nic_addr),
    .nic_en    (nic_en),
    .nic_en_wr (nic_en_wr),
    .nic_wdata (nic_wdata),
    .nic_rdata (nic_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    nic_rdata = '0;
    if (nic_en) begin
      case (nic_addr)
        2'b00:   nic_rdata = in_word;
        2'b01:   nic_rdata[63] = in_full;
        2'b11:   nic_rdata[63] = out_full;
        default: nic_rdata = '0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (nic_en && nic_en_wr && nic_addr == 2'b10) begin
      wr_count <= wr_count + 1;
      last_wr  <= nic_wdata;
    end
    if (nic_en && !nic_en_wr && nic_addr == 2'b00) rd_count <= rd_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Requester idx is already granted in IDLE; walk it through to IDLE again.
  task automatic serve_send(input int idx, input logic [63:0] word);
    tick();
    chk("contend_poll_addr", 64'(nic_addr), 64'h3);
    tick();
    chk("contend_xfer_word", 64'(nic_wdata), word);
    tick();
    chk("contend_done", 64'(done), 64'(2'b01 << idx));
    req[idx] = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0; req = '0; wr = '0; wdata = '0;
    out_full = 1'b0; in_full = 1'b0; in_word = '0;
    repeat (3) tick();
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_nic_en", 64'(nic_en), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    chk("reset_rdata", 64'(rdata), 64'h0);
    reset = 1'b1;
    tick();

    // Single send, output buffer empty
    req = 2'b01; wr = 2'b01; wdata[63:0] = SEND_W;
    tick();
    chk("send_poll_en", 64'(nic_en), 64'h1);
    chk("send_poll_addr", 64'(nic_addr), 64'h3);
    chk("send_poll_enwr", 64'(nic_en_wr), 64'h0);
    chk("send_busy", 64'(busy), 64'h1);
    tick();
    chk("send_xfer_addr", 64'(nic_addr), 64'h2);
    chk("send_xfer_enwr", 64'(nic_en_wr), 64'h1);
    chk("send_xfer_word", 64'(nic_wdata), SEND_W);
    tick();
    chk("send_done", 64'(done), 64'h1);
    chk("send_err", 64'(err), 64'h0);
    chk("send_done_nic_en", 64'(nic_en), 64'h0);
    chk("send_wr_count", 64'(wr_count), 64'h1);
    chk("send_last_wr", last_wr, SEND_W);
    req = 2'b00;
    tick();
    chk("send_idle_done", 64'(done), 64'h0);
    chk("send_idle_busy", 64'(busy), 64'h0);

    // Receive from requester 1 with five extra poll cycles
    req = 2'b10; wr = 2'b00; in_full = 1'b0;
    tick();
    chk("recv_poll_addr", 64'(nic_addr), 64'h1);
    repeat (4) tick();
    chk("recv_still_poll", 64'(nic_addr), 64'h1);
    tick();
    in_full = 1'b1; in_word = RECV_W;
    tick();
    chk("recv_xfer_addr", 64'(nic_addr), 64'h0);
    chk("recv_xfer_en", 64'(nic_en), 64'h1);
    tick();
    chk("recv_done", 64'(done), 64'h2);
    chk("recv_rdata", 64'(rdata), RECV_W);
    chk("recv_rd_count", 64'(rd_count), 64'h1);
    req = 2'b00; in_full = 1'b0;
    tick();
    chk("recv_rdata_hold", 64'(rdata), RECV_W);

    // Contention from reset: grants alternate 0,1,0,1
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wr = 2'b11; wdata = {WORD1, WORD0}; req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      serve_send(i % 2, (i % 2 == 0) ? WORD0 : WORD1);
      if (i < 3) req[i % 2] = 1'b1;
    end
    req = 2'b00;
    tick();

    // Abandoned receive by requester 0 leaves rr_ptr at 0
    snap = rd_count;
    req = 2'b01; wr = 2'b00; in_full = 1'b0;
    repeat (3) tick();
    req = 2'b00;
    tick();
    chk("abandon_busy", 64'(busy), 64'h0);
    chk("abandon_done", 64'(done), 64'h0);
    chk("abandon_no_read", 64'(rd_count), 64'(snap));
    req = 2'b11; wr = 2'b11; out_full = 1'b0;
    tick();
    tick();
    chk("abandon_ptr_word", 64'(nic_wdata), WORD0);
    tick();
    chk("abandon_ptr_done", 64'(done), 64'h1);
    req = 2'b00;
    tick();

    // Reset mid-POLL of requester 1 (rr_ptr is 1 here)
    req = 2'b10; wr = 2'b11; out_full = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_nic_en", 64'(nic_en), 64'h0);
    chk("midrst_addr", 64'(nic_addr), 64'h0);
    chk("midrst_wdata", 64'(nic_wdata), 64'h0);
    chk("midrst_rdata", 64'(rdata), 64'h0);
    reset = 1'b1; req = 2'b11; out_full = 1'b0;
    tick();
    tick();
    chk("midrst_ptr_word", 64'(nic_wdata), WORD0);
    tick();
    chk("midrst_ptr_done", 64'(done), 64'h1);
    req = 2'b00;
    tick();

`ifdef NIC_ARB_TIMEOUT_EN
    // Send with output buffer stuck full aborts after four polls
    snap = wr_count;
    req = 2'b01; wr = 2'b01; out_full = 1'b1;
    repeat (4) tick();
    chk("tmo_still_poll", 64'(nic_addr), 64'h3);
    tick();
    chk("tmo_done", 64'(done), 64'h1);
    chk("tmo_err", 64'(err), 64'h1);
    chk("tmo_no_write", 64'(wr_count), 64'(snap));
    req = 2'b00; out_full = 1'b0;
    tick();
    chk("tmo_idle", 64'(busy), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
